io_dma_arbiter: RTL
===================

// Module: io_dma_arbiter
// PURPOSE
//  Parametrised successor to the system-level I/O FSM. Arbitrates the single data-memory port
//  between the RSA CPU and the VGA scanout reader. Sequences CPU run -> guarded switchover ->
//  display. Holds the CPU in reset when it does not own memory. Measures CPU run length.
//  Sits in the system top between processor/VGA_Controller and data_memory.
// PARAMETERS
//  ADDR_W        19  memory address width
//  DATA_W        8   memory data width
//  STAT_W        32  width of CPU status word (reg_15)
//  DONE_BIT      0   status bit that signals "CPU finished"
//  GUARD_CYCLES  2   idle memory cycles between CPU release and VGA grant (0 = none)
//  CYC_W         32  run-length counter width
//  TIMEOUT_CYCLES 2**20  RUN watchdog limit (used only with RUN_TIMEOUT_EN)
// PORTS
//  clk         in   1       system clock
//  rst         in   1       asynchronous active-high reset
//  selected    in   1       user enable switch (level)
//  cpu_status  in   STAT_W  CPU status word; done = cpu_status[DONE_BIT]
//  cpu_addr    in   ADDR_W  CPU memory address
//  cpu_wren    in   1       CPU write enable
//  cpu_wdata   in   DATA_W  CPU write data
//  vga_addr    in   ADDR_W  VGA pixel address
//  mem_rdata   in   DATA_W  memory read data
//  mem_addr    out  ADDR_W  memory address
//  mem_wren    out  1       memory write enable
//  mem_wdata   out  DATA_W  memory write data (cpu_wdata passthrough)
//  cpu_rdata   out  DATA_W  read data to CPU
//  vga_rdata   out  DATA_W  read data to VGA
//  cpu_rst     out  1       CPU reset (rst OR not in RUN)
//  vga_en      out  1       VGA scanout enable
//  state_o     out  3       current state encoding
//  run_cycles  out  CYC_W   cycles spent in last/current RUN
//  fault       out  1       watchdog fault flag
// BEHAVIOUR
//  States: IDLE=0, RUN=1, SWITCH=2, DISPLAY=3, FAULT=4. Registered state; Moore outputs decoded
//   from state, so an input event takes effect on outputs one clk after the sampling edge.
//  Reset: state=IDLE, guard counter=0, run_cycles=0, fault=0. cpu_rst=1 combinationally while rst high.
//  IDLE: owner=none, mem_addr=vga_addr, mem_wren=0, vga_en=0, cpu_rst=1. selected -> RUN.
//  RUN: owner=CPU, mem_addr=cpu_addr, mem_wren=cpu_wren, cpu_rst=0.
//   !selected -> IDLE (highest priority); else done -> SWITCH (or DISPLAY if GUARD_CYCLES=0).
//  SWITCH: mem_addr=0, mem_wren=0, vga_en=0, cpu_rst=1; guard counter loaded with
//   GUARD_CYCLES-1 on entry, decrements each clk; at 0 -> DISPLAY. !selected -> IDLE.
//  DISPLAY: owner=VGA, mem_addr=vga_addr, mem_wren=0, vga_en=1, cpu_rst=1. !selected -> IDLE.
//  Read data: cpu_rdata=mem_rdata when owner=CPU else 0; vga_rdata=mem_rdata when owner=VGA else 0.
//  mem_wren is never 1 outside RUN; no CPU write can reach memory after done is sampled.
//  run_cycles: cleared on IDLE->RUN transition, +1 each clk in RUN, saturates at all-ones,
//   holds value outside RUN until next RUN entry.
//  done already set on first RUN cycle: honoured immediately (RUN lasts one cycle).
//  selected dropping mid-SWITCH/DISPLAY/FAULT: -> IDLE next clk; re-raising restarts CPU from reset.
//  Async rst mid-operation: immediate return to IDLE, all counters cleared.
//  Undefined state encodings -> IDLE.
// CONFIGURATION
//  RUN_TIMEOUT_EN defined: in RUN, when run_cycles == TIMEOUT_CYCLES-1 and done=0 -> FAULT.
//   FAULT: cpu_rst=1, mem_wren=0, vga_en=0, fault=1; !selected -> IDLE (fault cleared there).
//   done and timeout on same cycle: done wins (-> SWITCH). !selected beats both.
//  RUN_TIMEOUT_EN undefined: no FAULT state, no watchdog logic, fault tied 0, RUN unbounded.
// TESTING
//  rst, selected=1, status[0]=1 after 10 RUN clks -> RUN 10 clks, SWITCH 2 clks, DISPLAY, run_cycles=10.
//  RUN with cpu_wren=1, addr=0x100, data=0xA5 -> mem sees write; in SWITCH/DISPLAY cpu_wren=1 -> mem_wren=0.
//  selected=0 during DISPLAY -> IDLE next clk, vga_en=0, cpu_rst=1; selected=1 -> run_cycles restarts at 0.
//  GUARD_CYCLES=0, done -> RUN->DISPLAY directly; DISPLAY cpu_rdata=0, vga_rdata=mem_rdata.
//  RUN_TIMEOUT_EN, TIMEOUT_CYCLES=16, done never -> FAULT after 16 RUN clks, fault=1; done at clk 16 -> SWITCH.
//  rst pulsed mid-RUN (async, off-edge) -> state_o=0, cpu_rst=1 at once, run_cycles=0.

Source files
------------

// File: rtl/io_dma_arbiter_if.sv
// io_dma_arbiter_if: memory-port bundle shared by the CPU, the VGA reader and data memory.
//   slave  : arbiter side. Takes the CPU/VGA requests and memory read data, and drives the
//            memory request and the per-client read data.
//   master : environment side (CPU, VGA reader and data memory together).
// Signals:
//   cpu_addr/cpu_wren/cpu_wdata  CPU memory request
//   cpu_rdata                    read data returned to the CPU
//   vga_addr                     VGA pixel address
//   vga_rdata                    read data returned to the VGA reader
//   mem_addr/mem_wren/mem_wdata  request to data memory
//   mem_rdata                    data memory read data
interface io_dma_arbiter_if #(
   parameter int unsigned ADDR_W = 19,
   parameter int unsigned DATA_W = 8
);
   logic [ADDR_W-1:0] cpu_addr;
   logic              cpu_wren;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] cpu_rdata;
   logic [ADDR_W-1:0] vga_addr;
   logic [DATA_W-1:0] vga_rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_wren;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  cpu_addr, cpu_wren, cpu_wdata, vga_addr, mem_rdata,
      output mem_addr, mem_wren, mem_wdata, cpu_rdata, vga_rdata
   );

   modport master (
      output cpu_addr, cpu_wren, cpu_wdata, vga_addr, mem_rdata,
      input  mem_addr, mem_wren, mem_wdata, cpu_rdata, vga_rdata
   );
endinterface

// File: rtl/io_dma_arbiter.sv
// io_dma_arbiter: owns the single data-memory port and hands it between the CPU and the VGA
// scanout reader. Sequence is IDLE -> RUN (CPU) -> SWITCH (idle guard) -> DISPLAY (VGA).
// The CPU is held in reset whenever it does not own memory, and the length of each RUN is
// measured in clocks.
//
// Optional feature macro: RUN_TIMEOUT_EN adds a RUN watchdog and the FAULT state. Without it
// RUN is unbounded and fault is tied low.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   selected     user enable switch (level)
//   cpu_status   CPU status word; bit DONE_BIT means the CPU has finished
//   bus          memory-port bundle (slave side)
//   cpu_rst      CPU reset: high while rst is high or when not in RUN
//   vga_en       VGA scanout enable (DISPLAY only)
//   state_o      current state: IDLE=0 RUN=1 SWITCH=2 DISPLAY=3 FAULT=4
//   run_cycles   clocks spent in the last/current RUN (saturating)
//   fault        watchdog fault flag
module io_dma_arbiter #(
   parameter int unsigned ADDR_W         = 19,
   parameter int unsigned DATA_W         = 8,
   parameter int unsigned STAT_W         = 32,
   parameter int unsigned DONE_BIT       = 0,
   parameter int unsigned GUARD_CYCLES   = 2,
   parameter int unsigned CYC_W          = 32,
   parameter int unsigned TIMEOUT_CYCLES = 2**20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              selected,
   input  logic [STAT_W-1:0] cpu_status,
   io_dma_arbiter_if.slave   bus,
   output logic              cpu_rst,
   output logic              vga_en,
   output logic [2:0]        state_o,
   output logic [CYC_W-1:0]  run_cycles,
   output logic              fault
);

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StRun     = 3'd1,
      StSwitch  = 3'd2,
`ifdef RUN_TIMEOUT_EN
      StDisplay = 3'd3,
      StFault   = 3'd4
`else
      StDisplay = 3'd3
`endif
   } state_e;

   localparam int unsigned GuardW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
   localparam logic [GuardW-1:0] GuardLoad =
      GuardW'((GUARD_CYCLES == 0) ? 0 : GUARD_CYCLES - 1);

   state_e            state_q, state_d;
   logic [GuardW-1:0] guard_q;
   logic [CYC_W-1:0]  run_cycles_q;
   logic              done;
   logic              cpu_owner;
   logic              vga_owner;

   assign done = cpu_status[DONE_BIT];

   // Only the done bit of the status word matters here.
   logic unused_status;
   assign unused_status = ^{cpu_status, TIMEOUT_CYCLES[0]};

   // State register plus guard and run-length counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         guard_q      <= '0;
         run_cycles_q <= '0;
      end else begin
         state_q <= state_d;

         if (state_q != StSwitch && state_d == StSwitch) begin
            guard_q <= GuardLoad;
         end else if (state_q == StSwitch && guard_q != '0) begin
            guard_q <= guard_q - 1'b1;
         end

         if (state_q == StIdle && state_d == StRun) begin
            run_cycles_q <= '0;
         end else if (state_q == StRun && run_cycles_q != '1) begin
            run_cycles_q <= run_cycles_q + 1'b1;
         end
      end
   end

   // Next-state logic. Dropping selected always wins; done beats the watchdog.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (selected) state_d = StRun;
         end
         StRun: begin
            if (!selected) begin
               state_d = StIdle;
            end else if (done) begin
               state_d = (GUARD_CYCLES == 0) ? StDisplay : StSwitch;
`ifdef RUN_TIMEOUT_EN
            end else if (run_cycles_q == CYC_W'(TIMEOUT_CYCLES - 1)) begin
               state_d = StFault;
`endif
            end
         end
         StSwitch: begin
            if (!selected) begin
               state_d = StIdle;
            end else if (guard_q == '0) begin
               state_d = StDisplay;
            end
         end
         StDisplay: begin
            if (!selected) state_d = StIdle;
         end
`ifdef RUN_TIMEOUT_EN
         StFault: begin
            if (!selected) state_d = StIdle;
         end
`endif
         default: state_d = StIdle;
      endcase
   end

   // Moore outputs decoded from the registered state; mem_wren only ever passes in RUN.
   always_comb begin
      bus.mem_addr = '0;
      bus.mem_wren = 1'b0;
      cpu_rst      = 1'b1;
      vga_en       = 1'b0;
      cpu_owner    = 1'b0;
      vga_owner    = 1'b0;
      fault        = 1'b0;
      case (state_q)
         StIdle: begin
            bus.mem_addr = bus.vga_addr;
         end
         StRun: begin
            bus.mem_addr = bus.cpu_addr;
            bus.mem_wren = bus.cpu_wren;
            cpu_rst      = rst;
            cpu_owner    = 1'b1;
         end
         StSwitch: begin
            bus.mem_addr = '0;
         end
         StDisplay: begin
            bus.mem_addr = bus.vga_addr;
            vga_en       = 1'b1;
            vga_owner    = 1'b1;
         end
`ifdef RUN_TIMEOUT_EN
         StFault: begin
            fault = 1'b1;
         end
`endif
         default: begin
            bus.mem_addr = '0;
         end
      endcase
   end

   assign bus.mem_wdata = bus.cpu_wdata;
   assign bus.cpu_rdata = cpu_owner ? bus.mem_rdata : '0;
   assign bus.vga_rdata = vga_owner ? bus.mem_rdata : '0;
   assign state_o       = state_q;
   assign run_cycles    = run_cycles_q;

endmodule
